// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encoding, Booth digit one-hot encoding and the helper
// functions that derive the digit count and counter width from WIDTH.
package mul_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth digit: magnitude one-hot (one/two) plus a sign flag.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    localparam logic [2:0] DIG_ZERO = 3'b000;
    localparam logic [2:0] DIG_P1   = 3'b010;
    localparam logic [2:0] DIG_P2   = 3'b001;
    localparam logic [2:0] DIG_NEG  = 3'b100;

    // Number of radix-4 digits for a WIDTH-bit operand extended by two bits.
    function automatic int calc_n(input int width);
        return (width + 2) / 2;
    endfunction

    // Counter width able to hold the values 0..n.
    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: three overlapping multiplier bits are mapped to a
// digit in {0, +1, +2, -1, -2}, delivered as {neg, one, two}.
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] bits,
    output logic       neg,
    output logic       one,
    output logic       two
);

    booth_dig_t dig;

    // Recode the bit triplet; 000 and 111 both give a zero digit.
    always_comb begin
        dig = booth_dig_t'(DIG_ZERO);
        case (bits)
            3'b001, 3'b010: dig = booth_dig_t'(DIG_P1);
            3'b011:         dig = booth_dig_t'(DIG_P2);
            3'b100:         dig = booth_dig_t'(DIG_NEG | DIG_P2);
            3'b101, 3'b110: dig = booth_dig_t'(DIG_NEG | DIG_P1);
            default:        dig = booth_dig_t'(DIG_ZERO);
        endcase
    end

    assign neg = dig.neg;
    assign one = dig.one;
    assign two = dig.two;

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock cycle.
// Signed or unsigned operation is chosen per transfer with tc.
// Optional macro MUL_EARLY_TERM_EN: stop as soon as the remaining
// multiplier digits are all zero (latency 1..N instead of fixed N).
//
// The multiplicand is held pre-extended to the accumulator width and shifted
// left by two places per digit; the multiplier is shifted right by two places
// (filled with its own top bit), so the current digit is always in bits [2:0]
// and no variable shifters are needed.
module mul_booth_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int M  = WIDTH + 2;
    localparam int N  = calc_n(WIDTH);
    localparam int CW = calc_cw(N);
    localparam int AW = 2 * WIDTH + 4;

    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_t              state_r;
    logic [AW-1:0]       mc_r;
    logic [AW-1:0]       acc_r;
    logic [M:0]          mb_r;
    logic [CW-1:0]       k_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic [2*WIDTH-1:0]  product_r;

    logic [M-1:0]        a_ext_s;
    logic [M-1:0]        b_ext_s;
    logic                dig_neg_s;
    logic                dig_one_s;
    logic                dig_two_s;
    logic [AW-1:0]       pp_s;
    logic [AW-1:0]       addend_s;
    logic [AW-1:0]       acc_next_s;
    logic                term_s;
    logic                last_s;

    // Extend both operands by two bits: sign bits in signed mode, zeros otherwise.
    always_comb begin
        a_ext_s = {2'b00, a};
        b_ext_s = {2'b00, b};
        if (tc) begin
            a_ext_s = {{2{a[WIDTH-1]}}, a};
            b_ext_s = {{2{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {2'b00, a};
            b_ext_s = {2'b00, b};
        end
    end

    booth_r4_enc u_enc (
        .bits (mb_r[2:0]),
        .neg  (dig_neg_s),
        .one  (dig_one_s),
        .two  (dig_two_s)
    );

    // Partial product for the current digit; negative digits use the inverted
    // operand with a carry-in of one on the same addition.
    always_comb begin
        pp_s = {AW{1'b0}};
        if (dig_two_s) begin
            pp_s = {mc_r[AW-2:0], 1'b0};
        end else if (dig_one_s) begin
            pp_s = mc_r;
        end else begin
            pp_s = {AW{1'b0}};
        end
        if (dig_neg_s) begin
            addend_s = ~pp_s;
        end else begin
            addend_s = pp_s;
        end
        acc_next_s = acc_r + addend_s + {{(AW-1){1'b0}}, dig_neg_s};
    end

`ifdef MUL_EARLY_TERM_EN
    // Remaining digits are zero once the unconsumed multiplier bits, including
    // the overlap bit, are all equal.
    always_comb begin
        term_s = 1'b0;
        if ((mb_r[M:2] == {(M-1){1'b0}}) || (mb_r[M:2] == {(M-1){1'b1}})) begin
            term_s = 1'b1;
        end else begin
            term_s = 1'b0;
        end
    end
`else
    assign term_s = 1'b0;
`endif

    assign last_s = (k_r == K_LAST) || term_s;

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mc_r        <= {AW{1'b0}};
            acc_r       <= {AW{1'b0}};
            mb_r        <= {(M+1){1'b0}};
            k_r         <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            product_r   <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        mc_r       <= {{(AW-M){a_ext_s[M-1]}}, a_ext_s};
                        mb_r       <= {b_ext_s, 1'b0};
                        acc_r      <= {AW{1'b0}};
                        k_r        <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_next_s;
                    mc_r  <= {mc_r[AW-3:0], 2'b00};
                    mb_r  <= {{2{mb_r[M]}}, mb_r[M:2]};
                    k_r   <= k_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        product_r   <= acc_next_s[2*WIDTH-1:0];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq (WIDTH=16): directed vector table,
// hand-written multi-cycle sequences and randomized operations compared
// against an arithmetic reference model.
module tb_mul_booth_seq;

    localparam int W = 16;
    localparam int N = 9;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            tc;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            busy;

    int checks;
    int failures;

    mul_booth_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tc        (tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           tc;
        logic [2*W-1:0] exp;
        int             hold;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic t);
        longint xv;
        longint yv;
        longint p;
        if (t) begin
            xv = longint'($signed(x));
            yv = longint'($signed(y));
        end else begin
            xv = longint'(x);
            yv = longint'(y);
        end
        p = xv * yv;
        return p[2*W-1:0];
    endfunction

    // Expected latency in edges from accept to out_valid.
    function automatic int ref_lat(input logic [W-1:0] y, input logic t);
`ifdef MUL_EARLY_TERM_EN
        longint yv;
        longint rest;
        if (t) yv = longint'($signed(y));
        else   yv = longint'(y);
        for (int k = 0; k < N; k++) begin
            rest = yv >>> (2 * k + 1);
            if (rest == 64'sd0 || rest == -64'sd1) return k + 1;
        end
        return N;
`else
        return N;
`endif
    endfunction

    // Wait for out_valid, counting edges; lat=-1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            failures++;
            checks++;
            $display("FAIL timeout: out_valid not seen within 64 cycles");
        end
    endtask

    // One complete operation with optional result backpressure.
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic t, input logic [2*W-1:0] exp, input int hold,
                          input bit check_lat);
        int lat;
        logic [2*W-1:0] held;
        check({name, " idle_ready"}, longint'(in_ready), 64'd1);
        a = x; b = y; tc = t; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); tc = ~t;
        if (check_lat) begin
            check({name, " calc_in_ready"}, longint'(in_ready), 64'd0);
        end
        wait_out(lat);
        if (lat < 0) return;
        if (check_lat) check({name, " latency"}, longint'(lat), longint'(ref_lat(y, t)));
        check({name, " product"}, longint'(product), longint'(exp));
        held = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (product != held || !out_valid || in_ready || busy) begin
                check({name, " hold_stable"}, longint'({out_valid, in_ready, busy, product}),
                      longint'({3'b100, held}));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " post_hs"}, longint'({out_valid, in_ready, product}),
              longint'({2'b01, held}));
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; tc = 1'b0;

        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, 0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF, 2});
        vecs.push_back('{16'h0005, 16'h0005, 1'b0, 32'h0000_0019, 0});
        vecs.push_back('{16'h1234, 16'h0000, 1'b1, 32'h0000_0000, 0});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001, 0});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 0});
        vecs.push_back('{16'h0007, 16'hFFFD, 1'b1, 32'hFFFF_FFEB, 0});
        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 20});

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", longint'({in_ready, out_valid, busy, product}), longint'({3'b100, 32'h0}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].tc, vecs[i].exp,
                   vecs[i].hold, 1'b1);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a calculation.
        a = 16'h1234; b = 16'h4321; tc = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("mid_reset_outputs", longint'({in_ready, out_valid, busy, product}),
              longint'({3'b100, 32'h0}));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) check("abort_no_result", longint'({out_valid, busy}), 64'd0);
        end
        run_op("after_reset", 16'h0007, 16'hFFFD, 1'b1, 32'hFFFF_FFEB, 0, 1'b1);
        @(posedge clk);
        #1;

        // Operand waiting through DONE while the result is handshaken.
        a = 16'd3; b = 16'd4; tc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        a = 16'd5; b = 16'd6;
        wait_out(lat);
        check("b2b_first", longint'(product), 64'd12);
        @(posedge clk);
        #1;
        check("b2b_handshake", longint'({out_valid, in_ready, busy}), longint'(3'b010));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accept", longint'({in_ready, busy}), longint'(2'b01));
        wait_out(lat);
        check("b2b_second", longint'(product), 64'd30);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Randomized operations against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rt;
            ra = W'($urandom);
            rb = W'($urandom);
            rt = 1'($urandom);
            if (i % 8 == 0) rb = W'($urandom_range(0, 15));
            if (i % 8 == 1) rb = ~W'($urandom_range(0, 15));
            run_op($sformatf("rand%0d", i), ra, rb, rt, ref_mul(ra, rb, rt),
                   int'($urandom_range(0, 2)), 1'b1);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
